// File: rtl/traffic_phase_scheduler.sv
// Intersection phase scheduler: shares right-of-way between highway, farm road and
// pedestrians, timing each phase with one tick-driven down-counter.
module traffic_phase_scheduler #(
  parameter int TW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_i,
  input  logic [TW-1:0] ShortTime_i,
  input  logic [TW-1:0] LongTime_i,
  input  logic [TW-1:0] WalkTime_i,
  input  logic          FarmCar_i,
  input  logic          PedReq_i,
  output logic          HG,
  output logic          HY,
  output logic          HR,
  output logic          FG,
  output logic          FY,
  output logic          FR,
  output logic          Walk_o,
  output logic          FarmPending_o,
  output logic          PedPending_o,
  output logic [2:0]    State_o
);

  typedef enum logic [2:0] {
    S_HG = 3'd0,
    S_HY = 3'd1,
    S_FG = 3'd2,
    S_FY = 3'd3,
    S_PW = 3'd4,
    S_PC = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] cnt;
  logic [TW-1:0] dur_sel;
  logic          farm_req;
  logic          ped_req;
  logic          last_served_ped;
  logic          expire;
  logic          entering;

  // A zero duration is treated as one tick, so the load value never underflows.
  function automatic logic [TW-1:0] load_value(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  assign expire   = (cnt == '0) && tick_i;
  assign entering = (state_nxt != state);

  always_comb begin
    state_nxt = state;
    case (state)
      S_HG: if (expire && (farm_req || ped_req)) state_nxt = S_HY;
      S_HY: if (expire) begin
        if (farm_req && ped_req) state_nxt = last_served_ped ? S_FG : S_PW;
        else if (farm_req)       state_nxt = S_FG;
        else if (ped_req)        state_nxt = S_PW;
        else                     state_nxt = S_HG;
      end
      S_FG: if (expire) state_nxt = S_FY;
      S_FY: if (expire) state_nxt = S_HG;
      S_PW: if (expire) state_nxt = S_PC;
      S_PC: if (expire) state_nxt = S_HG;
      default: state_nxt = S_HG;
    endcase
  end

  always_comb begin
    dur_sel = LongTime_i;
    case (state_nxt)
      S_HY, S_FY, S_PC: dur_sel = ShortTime_i;
      S_PW:             dur_sel = WalkTime_i;
      default:          dur_sel = LongTime_i;
    endcase
  end

  // Request clears on the entry edge take priority over a simultaneous set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_HG;
      cnt             <= load_value(LongTime_i);
      farm_req        <= 1'b0;
      ped_req         <= 1'b0;
      last_served_ped <= 1'b1;
    end else begin
      state <= state_nxt;
      if (entering)                  cnt <= load_value(dur_sel);
      else if (tick_i && cnt != '0)  cnt <= cnt - TW'(1);

      if (entering && state_nxt == S_FG)                   farm_req <= 1'b0;
      else if (FarmCar_i && state != S_FG && state != S_FY) farm_req <= 1'b1;

      if (entering && state_nxt == S_PW)  ped_req <= 1'b0;
      else if (PedReq_i && state != S_PW) ped_req <= 1'b1;

      if (entering && state_nxt == S_FG)      last_served_ped <= 1'b0;
      else if (entering && state_nxt == S_PW) last_served_ped <= 1'b1;
    end
  end

  // Unreachable codes show all-red for their single cycle before recovery.
  always_comb begin
    {HG, HY, HR, FG, FY, FR, Walk_o} = 7'b0;
    case (state)
      S_HG: begin HG = 1'b1; FR = 1'b1; end
      S_HY: begin HY = 1'b1; FR = 1'b1; end
      S_FG: begin HR = 1'b1; FG = 1'b1; end
      S_FY: begin HR = 1'b1; FY = 1'b1; end
      S_PW: begin HR = 1'b1; FR = 1'b1; Walk_o = 1'b1; end
      S_PC: begin HR = 1'b1; FR = 1'b1; end
      default: begin HR = 1'b1; FR = 1'b1; end
    endcase
  end

  assign FarmPending_o = farm_req;
  assign PedPending_o  = ped_req;
  assign State_o       = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: phase-level behavioural model compared every cycle,
// directed phase-length scenarios with literal run lengths, then randomized traffic.
module tb_traffic_phase_scheduler;

  localparam int TW = 6;
  localparam int P_HG = 0, P_HY = 1, P_FG = 2, P_FY = 3, P_PW = 4, P_PC = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick_i = 1'b0;
  logic [TW-1:0] ShortTime_i = 6'd3;
  logic [TW-1:0] LongTime_i = 6'd5;
  logic [TW-1:0] WalkTime_i = 6'd4;
  logic          FarmCar_i = 1'b0;
  logic          PedReq_i = 1'b0;
  logic          HG, HY, HR, FG, FY, FR, Walk_o, FarmPending_o, PedPending_o;
  logic [2:0]    State_o;

  traffic_phase_scheduler #(.TW(TW)) dut (
    .clk(clk), .rst(rst), .tick_i(tick_i),
    .ShortTime_i(ShortTime_i), .LongTime_i(LongTime_i), .WalkTime_i(WalkTime_i),
    .FarmCar_i(FarmCar_i), .PedReq_i(PedReq_i),
    .HG(HG), .HY(HY), .HR(HR), .FG(FG), .FY(FY), .FR(FR), .Walk_o(Walk_o),
    .FarmPending_o(FarmPending_o), .PedPending_o(PedPending_o), .State_o(State_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  bit check_en = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Phase-level model: each phase remembers its duration and how many ticks it has served.
  int m_phase, m_dur, m_served;
  bit m_farm, m_ped, m_last_ped;

  function automatic int dur_of(input int ph);
    int t;
    case (ph)
      P_HY, P_FY, P_PC: t = ShortTime_i;
      P_PW:             t = WalkTime_i;
      default:          t = LongTime_i;
    endcase
    return (t == 0) ? 1 : t;
  endfunction

  function automatic logic [6:0] lamps_of(input int ph);
    case (ph)
      P_HG: return 7'b1000010;
      P_HY: return 7'b0100010;
      P_FG: return 7'b0011000;
      P_FY: return 7'b0010100;
      P_PW: return 7'b0010011;
      default: return 7'b0010010;
    endcase
  endfunction

  function automatic logic [31:0] model_vec();
    return {20'd0, lamps_of(m_phase), m_farm, m_ped, 3'(m_phase)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {20'd0, HG, HY, HR, FG, FY, FR, Walk_o, FarmPending_o, PedPending_o, State_o};
  endfunction

  always @(posedge clk) begin
    int nxt;
    bit done, nf, np;
    if (rst) begin
      m_phase = P_HG; m_dur = dur_of(P_HG); m_served = 0;
      m_farm = 0; m_ped = 0; m_last_ped = 1;
    end else begin
      nxt = m_phase;
      done = tick_i && (m_served + 1 >= m_dur);
      if (tick_i && !done) m_served++;
      if (done) begin
        case (m_phase)
          P_HG: if (m_farm || m_ped) nxt = P_HY;
          P_HY: begin
            if (m_farm && m_ped) nxt = m_last_ped ? P_FG : P_PW;
            else if (m_farm)     nxt = P_FG;
            else if (m_ped)      nxt = P_PW;
            else                 nxt = P_HG;
          end
          P_FG: nxt = P_FY;
          P_FY: nxt = P_HG;
          P_PW: nxt = P_PC;
          default: nxt = P_HG;
        endcase
      end
      nf = m_farm || (FarmCar_i && m_phase != P_FG && m_phase != P_FY);
      np = m_ped || (PedReq_i && m_phase != P_PW);
      if (nxt != m_phase) begin
        m_served = 0;
        m_dur = dur_of(nxt);
        if (nxt == P_FG) begin nf = 0; m_last_ped = 0; end
        if (nxt == P_PW) begin np = 0; m_last_ped = 1; end
        m_phase = nxt;
      end
      m_farm = nf;
      m_ped = np;
    end
  end

  always @(negedge clk) begin
    if (check_en) checkOutput("model", dut_vec(), model_vec());
  end

  // Run-length tracker: records (state, cycles) for each completed phase since last clear.
  typedef struct { int st; int len; } run_t;
  run_t runs_q[$];
  bit track_en = 1'b0;
  int cur_st, cur_len = 0;

  always @(negedge clk) begin
    if (track_en) begin
      if (cur_len == 0) begin cur_st = State_o; cur_len = 1; end
      else if (int'(State_o) == cur_st) cur_len++;
      else begin
        runs_q.push_back('{cur_st, cur_len});
        cur_st = State_o; cur_len = 1;
      end
    end
  end

  task automatic clear_tracker();
    runs_q.delete();
    cur_len = 0;
    track_en = 1'b1;
  endtask

  task automatic check_run(input string name, input int idx, input int st, input int len);
    if (idx < runs_q.size()) checkOutput(name, runs_q[idx].st * 256 + runs_q[idx].len, st * 256 + len);
    else checkOutput(name, 32'hFFFF_FFFF, st * 256 + len);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit t, input bit farm, input bit ped);
    tick_i = t; FarmCar_i = farm; PedReq_i = ped;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    applyStimulus(1, 0, 0);
    step();
    rst = 1'b0;
    clear_tracker();
  endtask

  task automatic wait_state(input string name, input int st, input int max_cycles);
    for (int i = 0; i < max_cycles && int'(State_o) != st; i++) step();
    checkOutput(name, State_o, st);
  endtask

  initial begin
    bit pulsed;
    // 1: idle highway
    do_reset();
    check_en = 1'b1;
    checkOutput("reset_vec", dut_vec(), 32'b1000010_00_000);
    checkOutput("reset_model", model_vec(), 32'b1000010_00_000);
    for (int i = 0; i < 30; i++) step();
    checkOutput("idle_vec", dut_vec(), 32'b1000010_00_000);
    checkOutput("idle_runs", runs_q.size(), 0);

    // 2: single farm pulse
    do_reset();
    applyStimulus(1, 1, 0); step();
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 24; i++) step();
    check_run("farm_hg", 0, P_HG, 5);
    check_run("farm_hy", 1, P_HY, 3);
    check_run("farm_fg", 2, P_FG, 5);
    check_run("farm_fy", 3, P_FY, 3);
    checkOutput("farm_end", dut_vec(), 32'b1000010_00_000);

    // 3: pedestrian cycle, with a second press during walk that must be ignored
    do_reset();
    applyStimulus(1, 0, 0); step(); step();
    applyStimulus(1, 0, 1); step();
    applyStimulus(1, 0, 0);
    pulsed = 0;
    for (int i = 0; i < 25; i++) begin
      if (!pulsed && State_o == 3'(P_PW)) begin
        applyStimulus(1, 0, 1); step(); applyStimulus(1, 0, 0);
        checkOutput("walk_press_vec", dut_vec(), 32'b0010011_00_100);
        pulsed = 1;
      end else step();
    end
    check_run("ped_hg", 0, P_HG, 5);
    check_run("ped_hy", 1, P_HY, 3);
    check_run("ped_pw", 2, P_PW, 4);
    check_run("ped_pc", 3, P_PC, 3);

    // 4: farm held plus a ped press: round-robin alternation
    do_reset();
    applyStimulus(1, 1, 1); step();
    applyStimulus(1, 1, 0);
    for (int i = 0; i < 55; i++) step();
    check_run("rr_hg0", 0, P_HG, 5);
    check_run("rr_hy0", 1, P_HY, 3);
    check_run("rr_fg0", 2, P_FG, 5);
    check_run("rr_fy0", 3, P_FY, 3);
    check_run("rr_hg1", 4, P_HG, 5);
    check_run("rr_hy1", 5, P_HY, 3);
    check_run("rr_pw", 6, P_PW, 4);
    check_run("rr_pc", 7, P_PC, 3);
    check_run("rr_hg2", 8, P_HG, 5);
    check_run("rr_hy2", 9, P_HY, 3);
    check_run("rr_fg1", 10, P_FG, 5);
    applyStimulus(1, 0, 0);

    // 5: sparse ticks, zero short time, long time changed mid farm-green
    ShortTime_i = 6'd0; LongTime_i = 6'd2;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      applyStimulus(k % 4 == 0, k == 0, 0);
      if (State_o == 3'(P_FG)) LongTime_i = 6'd9;
      step();
    end
    check_run("sparse_hy", 1, P_HY, 4);
    check_run("sparse_fg", 2, P_FG, 8);
    ShortTime_i = 6'd3; LongTime_i = 6'd5;

    // 6: reset during farm green with ped pending
    do_reset();
    applyStimulus(1, 1, 0); step();
    applyStimulus(1, 0, 0);
    wait_state("wait_fg", P_FG, 30);
    applyStimulus(1, 0, 1); step();
    applyStimulus(1, 0, 0);
    checkOutput("ped_pending_fg", PedPending_o, 1);
    rst = 1'b1; step(); rst = 1'b0;
    checkOutput("mid_reset_vec", dut_vec(), 32'b1000010_00_000);
    clear_tracker();
    applyStimulus(1, 1, 0); step();
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 10; i++) step();
    check_run("post_reset_hg", 0, P_HG, 5);

    // Randomized traffic against the model
    track_en = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        ShortTime_i = 6'($urandom_range(0, 6));
        LongTime_i  = 6'($urandom_range(0, 7));
        WalkTime_i  = 6'($urandom_range(0, 6));
      end
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus($urandom_range(0, 3) != 0,
                    ($urandom_range(0, 5) == 0) ? ~FarmCar_i : FarmCar_i,
                    $urandom_range(0, 9) == 0);
      step();
    end
    rst = 1'b0;
    step();
    check_en = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Intersection phase scheduler. Shares crossing right-of-way among three requesters: highway (default owner), farm-road vehicle sensor and pedestrian button.
- Sequences a single phase timer through programmable short, long and walk durations.
- Drives the six vehicle lamps plus the walk lamp. Sits between the sensor/button inputs and the lamp drivers, with a time-base enable from the system tick divider.

Parameters:
- TW, 6, width of all time inputs and of the phase timer.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tick_i  input  1  time-base enable; the timer counts only on clk edges where tick_i=1.
- ShortTime_i  input  TW  yellow and pedestrian-clear duration, in ticks.
- LongTime_i  input  TW  minimum highway green and fixed farm green duration, in ticks.
- WalkTime_i  input  TW  pedestrian walk duration, in ticks.
- FarmCar_i  input  1  farm-road vehicle sensor, level.
- PedReq_i  input  1  pedestrian button, pulse or level.
- HG, HY, HR  output  1 each  highway green, yellow, red.
- FG, FY, FR  output  1 each  farm green, yellow, red.
- Walk_o  output  1  pedestrian walk lamp.
- FarmPending_o  output  1  latched farm request.
- PedPending_o  output  1  latched pedestrian request.
- State_o  output  3  current state code.

Behaviour:
- States and codes: S_HG=0, S_HY=1, S_FG=2, S_FY=3, S_PW=4, S_PC=5. Codes 6 and 7 are illegal; they recover to S_HG on the next edge.
- Lamp decode is a combinational Moore decode of the state register:
  - S_HG: HG, FR.
  - S_HY: HY, FR.
  - S_FG: HR, FG.
  - S_FY: HR, FY.
  - S_PW: HR, FR, Walk_o.
  - S_PC: HR, FR.
  - Exactly one highway lamp and one farm lamp are on in every state.
- Timer:
  - On state entry, cnt is loaded with max(T,1)-1, where T is the duration input selected for the new state. A time input of 0 behaves as 1.
  - The time input is sampled only at load; changes mid-state have no effect.
  - cnt decrements on tick_i while non-zero and holds at 0.
  - expire = (cnt==0) & tick_i. Each timed state therefore lasts exactly max(T,1) ticks.
- Transitions:
  - S_HG -> S_HY: on expire & (farm_req | ped_req). Otherwise S_HG holds indefinitely.
  - S_HY (Short) -> arbitration on expire.
  - S_FG (Long) -> S_FY on expire.
  - S_FY (Short) -> S_HG on expire.
  - S_PW (Walk) -> S_PC on expire.
  - S_PC (Short) -> S_HG on expire.
  - S_HG loads LongTime_i on entry.
- Arbitration at S_HY expire:
  - Only farm_req: go to S_FG.
  - Only ped_req: go to S_PW.
  - Both: round-robin. Serve the requester that is not last_served. last_served updates on entry to S_FG or S_PW.
  - Neither (defensive): go to S_HG.
- Request latches:
  - farm_req sets on FarmCar_i=1 in any state except S_FG and S_FY; clears on entry to S_FG.
  - ped_req sets on PedReq_i=1 in any state except S_PW; clears on entry to S_PW.
  - Clear wins over set on the entry edge.
  - A FarmCar_i still high after S_FY re-latches in S_HG.
- Reset (rst=1 at an edge), regardless of current state:
  - state=S_HG; cnt loaded from LongTime_i; farm_req=0; ped_req=0; last_served=pedestrian, so farm wins the first tie.
  - Resulting outputs: HG=1, FR=1, all other lamps 0, Walk_o=0, pending outputs 0, State_o=0.
- A request asserted during reset is ignored.

Test Plan:
1. tick_i=1, Short=3, Long=5, Walk=4, no requests, 30 cycles after reset -> State_o=0, HG=1, FR=1 throughout.
2. FarmCar_i pulsed 1 cycle right after reset -> S_HG 5 cycles, S_HY 3, S_FG 5, S_FY 3, then S_HG holds; FarmPending_o clears on S_FG entry.
3. PedReq_i pulse during S_HG -> S_HY 3, S_PW 4 with Walk_o=1, HR=1, FR=1, then S_PC 3, then S_HG. A PedReq_i pulse during S_PW is ignored and PedPending_o stays 0.
4. FarmCar_i held high plus a PedReq_i pulse together -> farm served first (FG 5), then S_HG 5, HY 3, S_PW 4 (ped wins round-robin), then S_PC 3, HG 5, HY 3, FG 5 (farm re-latched).
5. tick_i high every 4th cycle, Short=0, Long=2, farm request -> S_HY lasts 1 tick (4 cycles), S_FG 2 ticks (8 cycles). Changing LongTime_i mid-S_FG does not alter its length.
6. rst asserted for 1 cycle mid-S_FG with ped pending -> next cycle State_o=0, HG=1, FR=1, both pending outputs 0, and a full Long minimum green follows.
